// File: rtl/stamp_trace_pkg.sv
// Shared configuration for the stamp_trace event log: vector and timer sizes,
// time-stamp formatting, CSR addresses and the FIFO entry layout.
package stamp_trace_pkg;

  localparam int VecSize            = 8;
  localparam int MonoTimerWidth     = 32;
  localparam int TimeStampWidth     = 24;  // must stay <= 24 to fit below the id field
  localparam int TimeStampPreScaler = 0;
  localparam int CsrAddrWidth       = 12;
  localparam int WordWidth          = 32;

  typedef logic [MonoTimerWidth-1:0] MonoTimerT;
  typedef logic [TimeStampWidth-1:0] TimeStampT;
  typedef logic [CsrAddrWidth-1:0]   CsrAddrT;
  typedef logic [WordWidth-1:0]      word_t;

  // Per-vector time-stamp CSRs occupy TimeStampCsrBase .. +VecSize-1; the
  // trace CSRs follow directly after them.
  localparam CsrAddrT TimeStampCsrBase = 12'hB00;
  localparam CsrAddrT TraceDataCsr     = TimeStampCsrBase + CsrAddrT'(VecSize);
  localparam CsrAddrT TraceStatusCsr   = TimeStampCsrBase + CsrAddrT'(VecSize + 1);

  localparam int TraceDepth   = 8;                 // power of two, >= 2
  localparam int TraceIdWidth = $clog2(VecSize);   // must stay <= 7

  typedef struct packed {
    logic [TraceIdWidth-1:0] id;
    TimeStampT               stamp;
  } TraceEntryT;

  // Index of the single set bit of a one-hot vector (0 when none is set).
  function automatic logic [TraceIdWidth-1:0] onehot_index(input logic [VecSize-1:0] oh);
    logic [TraceIdWidth-1:0] idx;
    idx = '0;
    for (int i = 0; i < VecSize; i++) begin
      if (oh[i]) idx = TraceIdWidth'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/trace_fifo.sv
// Parameterised synchronous FIFO with a combinational head. A push while full
// is accepted when a pop happens in the same cycle, since the pop frees the
// slot first. A pop while empty is ignored.
module trace_fifo #(
  parameter int Width = 8,
  parameter int Depth = 8
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     push_i,
  input  logic [Width-1:0]         data_i,
  input  logic                     pop_i,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(Depth):0]   count_o,
  output logic [Width-1:0]         head_o
);

  localparam int Aw = $clog2(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [Aw:0]      wr_q, wr_d;
  logic [Aw:0]      rd_q, rd_d;
  logic [Aw:0]      count_q, count_d;
  logic             pop_ok, push_ok;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (Aw+1)'(Depth));
  assign count_o = count_q;
  assign head_o  = mem_q[rd_q[Aw-1:0]];

  assign pop_ok  = pop_i && !empty_o;
  assign push_ok = push_i && (!full_o || pop_ok);

  // Pointer and occupancy next-state.
  always_comb begin
    wr_d    = wr_q;
    rd_d    = rd_q;
    count_d = count_q;
    if (push_ok) wr_d = wr_q + 1'b1;
    if (pop_ok)  rd_d = rd_q + 1'b1;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
    end
  end

  // Storage array; contents are don't-care while the slot is unoccupied.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_q[Aw-1:0]] <= data_i;
  end

endmodule

// File: rtl/stamp_trace.sv
// stamp_trace: logs each rising edge of pend[k] as {id, time stamp} into a
// small FIFO that software drains through TraceDataCsr / TraceStatusCsr.
// Optional build macro STAMP_TRACE_DROP_CNT_EN adds an 8-bit saturating count
// of dropped entries and merged repeat edges at TraceStatusCsr[23:16].
module stamp_trace
  import stamp_trace_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  MonoTimerT          mono_timer,
  input  logic [VecSize-1:0] pend,
  input  CsrAddrT            csr_addr,
  input  logic               csr_enable,
  output word_t              csr_out
);

  logic [VecSize-1:0] old_pend_q;
  logic [VecSize-1:0] capmask_q, capmask_d;
  logic [VecSize-1:0] pend_edge, req, grant;
  logic               grant_any;
  logic               ovf_q, ovf_d;
  logic               fifo_full, fifo_empty, fifo_pop, drop;
  logic               data_rd, status_rd;
  logic [$clog2(TraceDepth):0] fifo_count;
  TraceEntryT         wr_entry, head_entry;
  logic [7:0]         drop_cnt;

  assign pend_edge = pend & ~old_pend_q;
  assign req       = capmask_q | pend_edge;
  assign grant     = req & (~req + 1'b1);   // lowest set bit wins
  assign grant_any = |req;
  assign capmask_d = req & ~grant;

  assign wr_entry.id    = onehot_index(grant);
  assign wr_entry.stamp = TimeStampT'(mono_timer >> TimeStampPreScaler);

  assign data_rd   = csr_enable && (csr_addr == TraceDataCsr);
  assign status_rd = csr_enable && (csr_addr == TraceStatusCsr);
  assign fifo_pop  = data_rd && !fifo_empty;
  // The FIFO accepts a push while full only if a pop frees a slot this cycle.
  assign drop      = grant_any && fifo_full && !fifo_pop;
  // A clearing status read loses to an overflow in the same cycle.
  assign ovf_d     = (ovf_q && !status_rd) || drop;

  // Edge history, pending-capture mask and sticky overflow flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      old_pend_q <= pend;   // no spurious edges out of reset
      capmask_q  <= '0;
      ovf_q      <= 1'b0;
    end else begin
      old_pend_q <= pend;
      capmask_q  <= capmask_d;
      ovf_q      <= ovf_d;
    end
  end

`ifdef STAMP_TRACE_DROP_CNT_EN
  logic [7:0] drop_cnt_q, drop_cnt_d;
  logic [8:0] drop_inc, drop_sum;

  // A repeat edge on a bit still waiting in capmask merges into that capture.
  assign drop_inc = 9'($countones(pend_edge & capmask_q)) + 9'(drop);
  assign drop_sum = {1'b0, drop_cnt_q} + drop_inc;

  // Saturating drop counter; a status read clears it but keeps this cycle's losses.
  always_comb begin
    drop_cnt_d = drop_sum[8] ? 8'hFF : drop_sum[7:0];
    if (status_rd) drop_cnt_d = drop_inc[8] ? 8'hFF : drop_inc[7:0];
  end

  // Drop counter register.
  always_ff @(posedge clk) begin
    if (reset) drop_cnt_q <= '0;
    else       drop_cnt_q <= drop_cnt_d;
  end

  assign drop_cnt = drop_cnt_q;
`else
  assign drop_cnt = '0;
`endif

  trace_fifo #(
    .Width ($bits(TraceEntryT)),
    .Depth (TraceDepth)
  ) u_fifo (
    .clk_i   (clk),
    .reset_i (reset),
    .push_i  (grant_any),
    .data_i  (wr_entry),
    .pop_i   (fifo_pop),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count),
    .head_o  (head_entry)
  );

  // CSR read mux; unknown addresses and an empty FIFO read as zero.
  always_comb begin
    csr_out = '0;
    case (csr_addr)
      TraceDataCsr: begin
        if (!fifo_empty) begin
          csr_out[31]                   = 1'b1;
          csr_out[24 +: TraceIdWidth]   = head_entry.id;
          csr_out[TimeStampWidth-1:0]   = head_entry.stamp;
        end
      end
      TraceStatusCsr: begin
        csr_out[7:0]   = 8'(fifo_count);
        csr_out[23:16] = drop_cnt;
        csr_out[31]    = ovf_q;
      end
      default: csr_out = '0;
    endcase
  end

endmodule

// File: tb/tb_stamp_trace.sv
// Directed testbench for stamp_trace with hand-computed expected CSR values.
module tb_stamp_trace;
  import stamp_trace_pkg::*;

  // Clock and reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               reset;
  MonoTimerT          mono_timer;
  logic [VecSize-1:0] pend;
  CsrAddrT            csr_addr;
  logic               csr_enable;
  word_t              csr_out;

  stamp_trace dut (
    .clk        (clk),
    .reset      (reset),
    .mono_timer (mono_timer),
    .pend       (pend),
    .csr_addr   (csr_addr),
    .csr_enable (csr_enable),
    .csr_out    (csr_out)
  );

`ifdef STAMP_TRACE_DROP_CNT_EN
  localparam logic [31:0] ExpDrop = 32'h0002_0000;
`else
  localparam logic [31:0] ExpDrop = 32'h0000_0000;
`endif

  int tests_run    = 0;
  int tests_failed = 0;
  logic [31:0] exp_q[$];

  // Scoreboard check
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Driver: apply inputs for one cycle, return #1 after the edge
  task automatic step(input logic [VecSize-1:0] p, input MonoTimerT t,
                      input CsrAddrT a, input logic en);
    pend       = p;
    mono_timer = t;
    csr_addr   = a;
    csr_enable = en;
    @(posedge clk);
    #1;
    csr_enable = 1'b0;
  endtask

  // Side-effect-free CSR observation
  task automatic check_csr(input string tag, input CsrAddrT a, input logic [31:0] exp);
    csr_addr   = a;
    csr_enable = 1'b0;
    #1;
    check(tag, csr_out, exp);
  endtask

  function automatic logic [31:0] entry(input int id, input int stamp);
    return 32'h8000_0000 | (32'(id) << 24) | (32'(stamp) & 32'h00FF_FFFF);
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; pend = '0; mono_timer = '0; csr_addr = '0; csr_enable = 1'b0;

    // Reset with pend[2] held high, then release: no event
    step(8'h04, 32'h0, '0, 1'b0);
    step(8'h04, 32'h1, '0, 1'b0);
    check_csr("reset_status", TraceStatusCsr, 32'h0);
    check_csr("reset_data",   TraceDataCsr,   32'h0);
    reset = 1'b0;
    step(8'h04, 32'h2, '0, 1'b0);
    step(8'h04, 32'h3, '0, 1'b0);
    check_csr("post_reset_data",   TraceDataCsr,   32'h0);
    check_csr("post_reset_status", TraceStatusCsr, 32'h0);

    // Single edge on pend[3] at timer 0x100
    step(8'h08, 32'h100, '0, 1'b0);
    check_csr("single_data",   TraceDataCsr,   32'h8300_0100);
    check_csr("single_status", TraceStatusCsr, 32'h1);
    check_csr("other_addr",    CsrAddrT'(12'h123), 32'h0);
    step(8'h08, 32'h101, TraceDataCsr, 1'b0);
    check_csr("no_enable_no_pop", TraceStatusCsr, 32'h1);
    step(8'h08, 32'h102, TraceDataCsr, 1'b1);
    check_csr("single_popped", TraceStatusCsr, 32'h0);

    // pend[1] and pend[4] together: lowest id first, one cycle apart
    step(8'h1A, 32'h200, '0, 1'b0);
    step(8'h1A, 32'h201, '0, 1'b0);
    check_csr("dual_count", TraceStatusCsr, 32'h2);
    check_csr("dual_first", TraceDataCsr, entry(1, 32'h200));
    step(8'h1A, 32'h202, TraceDataCsr, 1'b1);
    check_csr("dual_second", TraceDataCsr, entry(4, 32'h201));
    step(8'h1A, 32'h203, TraceDataCsr, 1'b1);
    check_csr("dual_empty", TraceStatusCsr, 32'h0);

    // Depth+2 edges without reads: last two dropped, overflow set
    step(8'h00, 32'h2FF, '0, 1'b0);
    for (int i = 0; i < TraceDepth + 2; i++) begin
      step(VecSize'(1 << (i % VecSize)), MonoTimerT'(32'h300 + i), '0, 1'b0);
      if (i < TraceDepth) exp_q.push_back(entry(i % VecSize, 32'h300 + i));
    end
    check_csr("ovf_status", TraceStatusCsr, 32'h8000_0008 | ExpDrop);
    check_csr("ovf_head",   TraceDataCsr,   exp_q[0]);

    // Full FIFO: pop and new edge in the same cycle, push accepted
    check_csr("pop_push_head", TraceDataCsr, exp_q.pop_front());
    step(8'h04, 32'h400, TraceDataCsr, 1'b1);
    exp_q.push_back(entry(2, 32'h400));
    check_csr("pop_push_status", TraceStatusCsr, 32'h8000_0008 | ExpDrop);

    // Drain in order
    for (int i = 0; i < TraceDepth; i++) begin
      check_csr($sformatf("drain_%0d", i), TraceDataCsr, exp_q.pop_front());
      step(8'h04, 32'h500, TraceDataCsr, 1'b1);
    end
    check_csr("drained_data", TraceDataCsr, 32'h0);

    // Status reads: no side effect without enable, clear with enable
    check_csr("status_peek", TraceStatusCsr, 32'h8000_0000 | ExpDrop);
    step(8'h04, 32'h600, TraceStatusCsr, 1'b0);
    check_csr("status_no_clear", TraceStatusCsr, 32'h8000_0000 | ExpDrop);
    step(8'h04, 32'h601, TraceStatusCsr, 1'b1);
    check_csr("status_cleared", TraceStatusCsr, 32'h0);
    step(8'h04, 32'h602, TraceStatusCsr, 1'b1);
    check_csr("status_second", TraceStatusCsr, 32'h0);

    // Reset mid-drain discards queued events
    step(8'h05, 32'h700, '0, 1'b0);
    check_csr("pre_reset_count", TraceStatusCsr, 32'h1);
    reset = 1'b1;
    step(8'h05, 32'h701, '0, 1'b0);
    reset = 1'b0;
    step(8'h05, 32'h702, '0, 1'b0);
    check_csr("mid_reset_status", TraceStatusCsr, 32'h0);
    check_csr("mid_reset_data",   TraceDataCsr,   32'h0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
